// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - producer-side bus of the buffered UART transmitter
// master drives pushes/clears; slave (the transmitter) drives line and status.
interface uart_tx_fifo_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          transmit;
  logic [7:0]    data_tx;
  logic          clear_ovf;
  logic          tx;
  logic          busy_tx;
  logic          full;
  logic [CW-1:0] count;
  logic          overflow;

  modport master (
    output transmit, data_tx, clear_ovf,
    input  tx, busy_tx, full, count, overflow
  );

  modport slave (
    input  transmit, data_tx, clear_ovf,
    output tx, busy_tx, full, count, overflow
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - DEPTH-entry byte FIFO feeding an 8N1 serialiser
// Frames are sent back-to-back while bytes remain; pushes to a full FIFO are dropped.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 104,
  parameter int DEPTH        = 8
) (
  input  logic           clk,
  input  logic           nRst,
  uart_tx_fifo_if.slave  bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          ovf_q;

  state_t        state;
  logic [BW-1:0] baud;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          tx_q;

  logic          full_int;
  logic          push;
  logic          pop;
  logic          bit_end;

  always_comb begin
    full_int = (cnt == CW'(DEPTH));
    push     = bus.transmit && !full_int;
    bit_end  = (baud == BW'(CLKS_PER_BIT - 1));
    // The FSM only sees registered count, so a push into an empty FIFO waits a cycle
    pop      = (cnt != '0) && ((state == IDLE) || (state == STOP && bit_end));
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.data_tx;
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
      if (bus.transmit && full_int) begin
        ovf_q <= 1'b1;
      end else if (bus.clear_ovf) begin
        ovf_q <= 1'b0;
      end
    end
  end

  // tx is registered from the current state, so the line trails the FSM by one cycle
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state)
        START:   tx_q <= 1'b0;
        DATA:    tx_q <= shreg[0];
        default: tx_q <= 1'b1;
      endcase

      case (state)
        IDLE: begin
          baud <= '0;
          if (pop) begin
            shreg <= mem[rd_ptr];
            state <= START;
          end
        end
        START: begin
          if (bit_end) begin
            baud    <= '0;
            bit_idx <= '0;
            state   <= DATA;
          end else begin
            baud <= baud + BW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            baud  <= '0;
            shreg <= {1'b0, shreg[7:1]};
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            baud <= '0;
            if (pop) begin
              shreg <= mem[rd_ptr];
              state <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.tx       = tx_q;
  assign bus.busy_tx  = (state != IDLE) || (cnt != '0);
  assign bus.full     = full_int;
  assign bus.count    = cnt;
  assign bus.overflow = ovf_q;
endmodule
